// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
//
// Arbitrates four requesters onto the write port of an 8 x 8-bit register bank.
// A write takes three cycles: IDLE (select and capture), WRITE (the bank
// register is loaded on the edge that leaves WRITE), and ACK (a one-cycle
// completion pulse to the owner). The read port is combinational and
// independent of the write path.
//
// Configuration:
//   ROUND_ROBIN_EN  defined   -> round-robin arbitration. A pointer advances to
//                                (winner+1) mod 4 when ACK completes.
//                   undefined -> fixed priority. Requester 0 is highest and 3
//                                is lowest.
//
// Ports:
//   clk      in   1   single clock; all state changes on the rising edge
//   rst      in   1   synchronous, active-high reset
//   req      in   4   per-requester write request (bit i = requester i)
//   wr_addr  in  12   packed 4 x 3-bit register index; [3i+2:3i] = requester i
//   wr_data  in  32   packed 4 x 8-bit write data;     [8i+7:8i] = requester i
//   rd_addr  in   3   read port register index
//   rd_data  out  8   combinational read of bank[rd_addr]
//   grant    out  4   registered one-hot owner of the write port
//   ack      out  4   one-hot, single-cycle completion pulse (equals grant in ACK)
//   busy     out  1   high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module reg_write_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [11:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [2:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic [3:0]  grant,
  output logic [3:0]  ack,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  logic [1:0] r_state;
  logic [3:0] r_grant;
  logic [2:0] r_addr;
  logic [7:0] r_data;
  logic [7:0] r_bank [8];

  logic       w_win_valid;
  logic [1:0] w_win_idx;
  logic [2:0] w_sel_addr;
  logic [7:0] w_sel_data;
  logic [7:0] w_load;

  // ---------------------------------------------------------------------------
  // Winner selection (combinational, consumed only in IDLE)
  // ---------------------------------------------------------------------------
`ifdef ROUND_ROBIN_EN
  logic [1:0] r_ptr;
  logic [1:0] r_win_idx;

  // Search from the pointer upward with wrap-around. Walking the offsets from
  // high to low lets the smallest offset, the highest priority, win last.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // assignment; a path that leaves it unassigned would infer a latch.
    w_win_valid = 1'b0;
    w_win_idx   = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[r_ptr + 2'(k)]) begin
        w_win_valid = 1'b1;
        w_win_idx   = r_ptr + 2'(k);
      end
    end
  end

  // The pointer advances on the edge that leaves ACK. This means a request
  // that is still held is seen against the new order in the very next IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= 2'd0;
      r_win_idx <= 2'd0;
    end else begin
      if (r_state == ST_IDLE && w_win_valid) begin
        r_win_idx <= w_win_idx;
      end
      if (r_state == ST_ACK) begin
        r_ptr <= r_win_idx + 2'd1;
      end
    end
  end
`else
  // Fixed priority. The lowest requester index wins.
  always_comb begin
    w_win_valid = |req;
    w_win_idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) begin
        w_win_idx = 2'(k);
      end
    end
  end
`endif

  // Extract the winner's slice of the packed address and data buses.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (w_win_idx == 2'(i)) begin
        w_sel_addr = wr_addr[3*i +: 3];
        w_sel_data = wr_data[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM. The address and data are captured once in IDLE. This makes
  // later changes on the requester's bus, or a dropped req, irrelevant.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples pre-edge values regardless of statement order.
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_valid) begin
            r_state <= ST_WRITE;
            r_grant <= 4'b0001 << w_win_idx;
            r_addr  <= w_sel_addr;
            r_data  <= w_sel_data;
          end
        end
        ST_WRITE: begin
          r_state <= ST_ACK;
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register bank: one load enable per register, raised only in WRITE.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_load = '0;
    if (r_state == ST_WRITE) begin
      w_load[r_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the bank is explicitly reset because its contents must read as
      // 0x00 after reset. Reset also overrides a write in flight.
      for (int i = 0; i < 8; i++) begin
        r_bank[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_load[i]) begin
          r_bank[i] <= r_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign grant   = r_grant;
  assign ack     = (r_state == ST_ACK) ? r_grant : 4'b0000;
  assign busy    = (r_state != ST_IDLE);
  assign rd_data = r_bank[rd_addr];

endmodule
